// File: rtl/mem_bus_responder_if.sv
// Multiplexed address/data memory bus between processor control unit and memory.
// Processor drives address/data, ALE and the active-low strobes.
// Memory returns registered read data, its drive enable, Ready and Error.
interface mem_bus_responder_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] DataOut;
  logic              DataOutEn;
  logic              ALE;
  logic              nME;
  logic              nOE;
  logic              nWE;
  logic              Ready;
  logic              Error;

  modport master (
    output DataIn, ALE, nME, nOE, nWE,
    input  DataOut, DataOutEn, Ready, Error
  );

  modport slave (
    input  DataIn, ALE, nME, nOE, nWE,
    output DataOut, DataOutEn, Ready, Error
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the ALE/nME/nOE/nWE multiplexed bus with internal RAM.
// Read data / write commit after WAIT_STATES extra edges (same edge when 0).
// No backpressure: Ready signals completion; an early strobe release aborts the access.
module mem_bus_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  mem_bus_responder_if.slave   bus
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
  localparam bit         NO_WAIT  = (WAIT_STATES == 0);

  typedef enum logic [2:0] {IDLE, ADDR, RD, WR, HOLD, ERR} state_t;

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wrData;
  logic [DATA_W-1:0] dataOutReg;
  logic              dataOutEnReg;
  logic              readyReg;
  logic              errorReg;
  logic [3:0]        count;

  logic [DATA_W-1:0] mem [DEPTH];

  // Per-edge actions decided by the output process
  logic              readyNext;
  logic              dataOutEnNext;
  logic              errorNext;
  logic              latchAddr;
  logic              captureWr;
  logic              loadCount;
  logic              loadRead;
  logic              memWe;
  logic [DATA_W-1:0] memWData;

  logic bothHigh;
  assign bothHigh = bus.nOE && bus.nWE;

  // State register plus the datapath registers it controls
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      addrReg      <= '0;
      wrData       <= '0;
      dataOutReg   <= '0;
      dataOutEnReg <= 1'b0;
      readyReg     <= 1'b0;
      errorReg     <= 1'b0;
      count        <= '0;
    end else begin
      state        <= stateNext;
      dataOutEnReg <= dataOutEnNext;
      readyReg     <= readyNext;
      errorReg     <= errorNext;
      if (latchAddr) addrReg <= bus.DataIn[ADDR_W-1:0];
      if (captureWr) wrData <= bus.DataIn;
      if (loadRead)  dataOutReg <= mem[addrReg];
      if (loadCount) count <= WAIT_CNT;
      else if ((state == RD || state == WR) && count != 4'd0) count <= count - 4'd1;
    end
  end

  // RAM write port; reset suppresses the commit so an in-flight write is dropped
  always_ff @(posedge Clock) begin
    if (memWe && !Reset) mem[addrReg] <= memWData;
  end

  // Next-state: nME release beats ALE, ALE beats the strobes
  always_comb begin
    stateNext = state;
    if (bus.nME) begin
      stateNext = IDLE;
    end else if (bus.ALE) begin
      stateNext = ADDR;
    end else begin
      case (state)
        IDLE: stateNext = IDLE;
        ADDR: begin
          if (!bus.nOE && !bus.nWE) stateNext = ERR;
          else if (!bus.nOE)        stateNext = NO_WAIT ? HOLD : RD;
          else if (!bus.nWE)        stateNext = NO_WAIT ? HOLD : WR;
        end
        RD: begin
          if (bus.nOE)              stateNext = ADDR;
          else if (count == 4'd1)   stateNext = HOLD;
        end
        WR: begin
          if (bus.nWE)              stateNext = ADDR;
          else if (count == 4'd1)   stateNext = HOLD;
        end
        HOLD: if (bothHigh) stateNext = ADDR;
        ERR:  if (bothHigh) stateNext = ADDR;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Output/action decode: what the registers and RAM do on this edge
  always_comb begin
    readyNext     = readyReg;
    dataOutEnNext = dataOutEnReg;
    errorNext     = 1'b0;
    latchAddr     = 1'b0;
    captureWr     = 1'b0;
    loadCount     = 1'b0;
    loadRead      = 1'b0;
    memWe         = 1'b0;
    memWData      = wrData;
    if (bus.nME) begin
      readyNext     = 1'b0;
      dataOutEnNext = 1'b0;
    end else if (bus.ALE) begin
      latchAddr     = 1'b1;
      readyNext     = 1'b0;
      dataOutEnNext = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (!bus.nOE && !bus.nWE) begin
            errorNext = 1'b1;
          end else if (!bus.nOE) begin
            if (NO_WAIT) begin
              loadRead      = 1'b1;
              dataOutEnNext = 1'b1;
              readyNext     = 1'b1;
            end else begin
              loadCount = 1'b1;
            end
          end else if (!bus.nWE) begin
            captureWr = 1'b1;
            if (NO_WAIT) begin
              memWe     = 1'b1;
              memWData  = bus.DataIn;
              readyNext = 1'b1;
            end else begin
              loadCount = 1'b1;
            end
          end
        end
        RD: begin
          if (!bus.nOE && count == 4'd1) begin
            loadRead      = 1'b1;
            dataOutEnNext = 1'b1;
            readyNext     = 1'b1;
          end
        end
        WR: begin
          if (!bus.nWE && count == 4'd1) begin
            memWe     = 1'b1;
            readyNext = 1'b1;
          end
        end
        HOLD: begin
          if (bothHigh) begin
            readyNext     = 1'b0;
            dataOutEnNext = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.DataOut   = dataOutReg;
  assign bus.DataOutEn = dataOutEnReg;
  assign bus.Ready     = readyReg;
  assign bus.Error     = errorReg;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: vector table on a zero-wait instance, hand sequences on a 3-wait instance.
module tb_mem_bus_responder;

  logic Clock;
  logic Reset;

  mem_bus_responder_if #(.DATA_W(16)) bus0();
  mem_bus_responder_if #(.DATA_W(16)) bus1();

  mem_bus_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .bus(bus0)
  );
  mem_bus_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(3)) dut1 (
    .Clock(Clock), .Reset(Reset), .bus(bus1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst;
    logic        ale;
    logic        nme;
    logic        noe;
    logic        nwe;
    logic [15:0] din;
    logic [15:0] eOut;
    logic        eEn;
    logic        eRdy;
    logic        eErr;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nFail   = 0;

  function automatic vec_t mkV(logic rst, logic ale, logic nme, logic noe, logic nwe,
                               logic [15:0] din, logic [15:0] eOut,
                               logic eEn, logic eRdy, logic eErr);
    vec_t v;
    v.rst = rst; v.ale = ale; v.nme = nme; v.noe = noe; v.nwe = nwe; v.din = din;
    v.eOut = eOut; v.eEn = eEn; v.eRdy = eRdy; v.eErr = eErr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one edge and settle before sampling
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drv0(input logic ale, input logic nme, input logic noe, input logic nwe,
                      input logic [15:0] din);
    bus0.ALE = ale; bus0.nME = nme; bus0.nOE = noe; bus0.nWE = nwe; bus0.DataIn = din;
  endtask

  task automatic drv1(input logic ale, input logic nme, input logic noe, input logic nwe,
                      input logic [15:0] din);
    bus1.ALE = ale; bus1.nME = nme; bus1.nOE = noe; bus1.nWE = nwe; bus1.DataIn = din;
  endtask

  function automatic logic [31:0] out1();
    return {13'd0, bus1.DataOut, bus1.DataOutEn, bus1.Ready, bus1.Error};
  endfunction

  function automatic logic [31:0] exp1(logic [15:0] d, logic en, logic rdy, logic err);
    return {13'd0, d, en, rdy, err};
  endfunction

  initial begin
    Reset = 1'b1;
    drv0(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    drv1(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);

    //                rst ale nme noe nwe  din       eOut     en rdy err
    // reset, preload 0x1234 @ 0x05, reset again, read it back
    vecs.push_back(mkV(1, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mkV(1, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mkV(1, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mkV(0, 1, 0, 1, 1, 16'h0005, 16'h0000, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 1, 0, 16'h1234, 16'h0000, 0, 1, 0));
    vecs.push_back(mkV(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mkV(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mkV(0, 1, 0, 1, 1, 16'h0005, 16'h0000, 0, 0, 0));
    // zero-wait fetch
    vecs.push_back(mkV(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 1, 1, 0));
    vecs.push_back(mkV(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 1, 1, 0));
    vecs.push_back(mkV(0, 0, 0, 1, 1, 16'h0000, 16'h1234, 0, 0, 0));
    // 0x10 = 0xA5A5, then both strobes low -> single Error pulse, no write
    vecs.push_back(mkV(0, 1, 0, 1, 1, 16'h0010, 16'h1234, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 1, 0, 16'hA5A5, 16'h1234, 0, 1, 0));
    vecs.push_back(mkV(0, 0, 0, 1, 1, 16'h0000, 16'h1234, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 0, 0, 16'h5A5A, 16'h1234, 0, 0, 1));
    vecs.push_back(mkV(0, 0, 0, 0, 0, 16'h5A5A, 16'h1234, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 1, 1, 16'h0000, 16'h1234, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 0, 1, 16'h0000, 16'hA5A5, 1, 1, 0));
    vecs.push_back(mkV(0, 0, 0, 1, 1, 16'h0000, 16'hA5A5, 0, 0, 0));
    // 0x06 = 0xC0DE, then aliased ALE 0xFF05 and back-to-back reads
    vecs.push_back(mkV(0, 1, 0, 1, 1, 16'h0006, 16'hA5A5, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 1, 0, 16'hC0DE, 16'hA5A5, 0, 1, 0));
    vecs.push_back(mkV(0, 0, 0, 1, 1, 16'h0000, 16'hA5A5, 0, 0, 0));
    vecs.push_back(mkV(0, 1, 0, 1, 1, 16'hFF05, 16'hA5A5, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 1, 1, 0));
    vecs.push_back(mkV(0, 0, 0, 1, 1, 16'h0000, 16'h1234, 0, 0, 0));
    vecs.push_back(mkV(0, 1, 0, 1, 1, 16'h0006, 16'h1234, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 0, 1, 16'h0000, 16'hC0DE, 1, 1, 0));
    vecs.push_back(mkV(0, 0, 0, 1, 1, 16'h0000, 16'hC0DE, 0, 0, 0));
    // IDLE ignores strobes, no Error
    vecs.push_back(mkV(0, 0, 1, 1, 1, 16'h0000, 16'hC0DE, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 0, 1, 16'h0000, 16'hC0DE, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 0, 0, 16'h0000, 16'hC0DE, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 1, 1, 1, 16'h0000, 16'hC0DE, 0, 0, 0));
    // ALE beats nOE; nME beats ALE
    vecs.push_back(mkV(0, 1, 0, 0, 1, 16'h0005, 16'hC0DE, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 1, 1, 0));
    vecs.push_back(mkV(0, 0, 1, 1, 1, 16'h0000, 16'h1234, 0, 0, 0));
    vecs.push_back(mkV(0, 1, 1, 1, 1, 16'h0006, 16'h1234, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 0, 0, 0));
    vecs.push_back(mkV(0, 0, 1, 1, 1, 16'h0000, 16'h1234, 0, 0, 0));

    foreach (vecs[i]) begin
      Reset = vecs[i].rst;
      drv0(vecs[i].ale, vecs[i].nme, vecs[i].noe, vecs[i].nwe, vecs[i].din);
      tick();
      check($sformatf("vec%0d", i),
            {13'd0, bus0.DataOut, bus0.DataOutEn, bus0.Ready, bus0.Error},
            {13'd0, vecs[i].eOut, vecs[i].eEn, vecs[i].eRdy, vecs[i].eErr});
    end
    Reset = 1'b0;
    drv0(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);

    // 3 wait states: write 0xBEEF to 0x2A, Ready exactly 3 edges after nWE sampled
    drv1(1'b1, 1'b0, 1'b1, 1'b1, 16'h002A); tick();
    drv1(1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    for (int k = 0; k <= 3; k++) begin
      tick();
      check($sformatf("ws3_wr_edge%0d", k), out1(), exp1(16'h0000, 1'b0, (k == 3), 1'b0));
    end
    drv1(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000); tick();
    check("ws3_wr_release", out1(), exp1(16'h0000, 1'b0, 1'b0, 1'b0));

    // read back: data valid exactly 3 edges after nOE sampled
    drv1(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int k = 0; k <= 3; k++) begin
      tick();
      check($sformatf("ws3_rd_edge%0d", k), out1(),
            (k == 3) ? exp1(16'hBEEF, 1'b1, 1'b1, 1'b0) : exp1(16'h0000, 1'b0, 1'b0, 1'b0));
    end
    drv1(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000); tick();
    check("ws3_rd_release", out1(), exp1(16'hBEEF, 1'b0, 1'b0, 1'b0));

    // write aborted by early nWE release: no commit
    drv1(1'b0, 1'b0, 1'b1, 1'b0, 16'h1111); tick();
    drv1(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000); tick(); tick(); tick();
    check("ws3_abort_no_ready", out1(), exp1(16'hBEEF, 1'b0, 1'b0, 1'b0));
    drv1(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick(); tick(); tick(); tick();
    check("ws3_abort_old_data", out1(), exp1(16'hBEEF, 1'b1, 1'b1, 1'b0));
    drv1(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000); tick();

    // Reset mid-RD: outputs cleared, and IDLE ignores the still-low nOE
    drv1(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick(); tick();
    Reset = 1'b1; tick();
    check("ws3_rst_mid_rd", out1(), exp1(16'h0000, 1'b0, 1'b0, 1'b0));
    Reset = 1'b0;
    tick(); tick(); tick(); tick();
    check("ws3_rst_then_idle", out1(), exp1(16'h0000, 1'b0, 1'b0, 1'b0));

    // nME release mid-RD
    drv1(1'b1, 1'b0, 1'b1, 1'b1, 16'h002A); tick();
    drv1(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick(); tick();
    drv1(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000); tick();
    check("ws3_nme_mid_rd", out1(), exp1(16'h0000, 1'b0, 1'b0, 1'b0));
    drv1(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick(); tick(); tick(); tick();
    check("ws3_nme_then_idle", out1(), exp1(16'h0000, 1'b0, 1'b0, 1'b0));

    // Reset mid-WR: target word keeps 0xBEEF
    drv1(1'b1, 1'b0, 1'b1, 1'b1, 16'h002A); tick();
    drv1(1'b0, 1'b0, 1'b1, 1'b0, 16'hDEAD); tick(); tick();
    Reset = 1'b1; tick();
    Reset = 1'b0;
    drv1(1'b1, 1'b0, 1'b1, 1'b1, 16'h002A); tick();
    drv1(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick(); tick(); tick(); tick();
    check("ws3_rst_mid_wr", out1(), exp1(16'hBEEF, 1'b1, 1'b1, 1'b0));
    drv1(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
